// File: rtl/sprite1_ctrl.sv
// Sprite-1 compositing: hit test against a frame-shadowed position, RAM addressing, colour merge.
// Optional horizontal mirroring is built when SPRITE1_FLIPX_EN is defined.
module sprite1_ctrl #(
  parameter int SPRITE_SIZE = 16,
  parameter int BLINK_BIT   = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [23:0] bg_rgb,
  input  logic [31:0] sprite_data,
  input  logic [31:0] sprite_pixel,
  output logic        in_sprite,
  output logic [3:0]  rel_x,
  output logic [3:0]  rel_y,
  output logic        out_valid,
  output logic [23:0] out_rgb,
  output logic        hit,
  output logic [5:0]  frame_count
);

  logic [31:0] shadow;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit1;
  logic        blanked;
  logic [3:0]  rel_x_nxt;
  logic        vld_p1;
  logic [23:0] bg_p1;
  logic        opaque_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shadow      <= '0;
      frame_count <= '0;
    end else if (frame_start) begin
      shadow      <= sprite_data;
      frame_count <= frame_count + 6'd1;
    end
  end

  // Negative offsets wrap to large unsigned values and fail the range test.
  always_comb begin
    dx      = {1'b0, pix_x} - {1'b0, shadow[9:0]};
    dy      = {1'b0, pix_y} - {2'b0, shadow[18:10]};
    blanked = shadow[29] & frame_count[BLINK_BIT];
    hit1    = pix_valid & shadow[31] & ~blanked &
              (dx < 11'(SPRITE_SIZE)) & (dy < 11'(SPRITE_SIZE));
`ifdef SPRITE1_FLIPX_EN
    rel_x_nxt = shadow[30] ? (4'd15 - dx[3:0]) : dx[3:0];
`else
    rel_x_nxt = dx[3:0];
`endif
  end

  // Stage 1: RAM address and delayed background
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      in_sprite <= 1'b0;
      rel_x     <= '0;
      rel_y     <= '0;
      vld_p1    <= 1'b0;
      bg_p1     <= '0;
    end else begin
      in_sprite <= hit1;
      rel_x     <= hit1 ? rel_x_nxt : 4'd0;
      rel_y     <= hit1 ? dy[3:0]   : 4'd0;
      vld_p1    <= pix_valid;
      bg_p1     <= bg_rgb;
    end
  end

  assign opaque_hit = in_sprite & sprite_pixel[24];

  // Stage 2: merge RAM pixel over background
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      out_rgb   <= '0;
    end else begin
      out_valid <= vld_p1;
      hit       <= opaque_hit;
      if (!vld_p1)
        out_rgb <= '0;
      else
        out_rgb <= opaque_hit ? sprite_pixel[23:0] : bg_p1;
    end
  end

`ifdef SPRITE1_FLIPX_EN
  logic unused_bits;
  assign unused_bits = ^{sprite_pixel[31:25], shadow[28:19]};
`else
  logic unused_bits;
  assign unused_bits = ^{sprite_pixel[31:25], shadow[30], shadow[28:19]};
`endif

endmodule

// File: tb/tb_sprite1_ctrl.sv
// Scoreboard bench for sprite1_ctrl: a behavioural model queues expected RAM addresses and pixels.
module tb_sprite1_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] bg_rgb;
  logic [31:0] sprite_data;
  logic [31:0] sprite_pixel;
  logic        in_sprite;
  logic [3:0]  rel_x;
  logic [3:0]  rel_y;
  logic        out_valid;
  logic [23:0] out_rgb;
  logic        hit;
  logic [5:0]  frame_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        ram_en   = 1'b0;
  logic [31:0] ram_word = '0;

  logic [31:0] m_sh;
  logic [5:0]  m_fc;
  logic [14:0] q1[$];
  logic [56:0] q2[$];

  sprite1_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .bg_rgb(bg_rgb),
    .sprite_data(sprite_data), .sprite_pixel(sprite_pixel),
    .in_sprite(in_sprite), .rel_x(rel_x), .rel_y(rel_y),
    .out_valid(out_valid), .out_rgb(out_rgb), .hit(hit), .frame_count(frame_count)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] ram_fn(input logic [3:0] rx, input logic [3:0] ry);
    return ram_en ? ram_word : {7'd0, 1'b1, 8'h5A, ry, rx, 8'hC3};
  endfunction

  // Sprite RAM stand-in: combinational read addressed by the DUT.
  assign sprite_pixel = ram_fn(rel_x, rel_y);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pix(input logic v, input int x, input int y, input logic [23:0] bg,
                     input logic fs);
    logic [10:0] dx, dy;
    logic        h;
    logic [3:0]  rx, ry;
    logic [31:0] sp;
    logic        oh;
    @(negedge HCLK);
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    bg_rgb      = bg;
    frame_start = fs;
    dx = 11'(x) - {1'b0, m_sh[9:0]};
    dy = 11'(y) - {2'b0, m_sh[18:10]};
    h  = v && m_sh[31] && !(m_sh[29] && m_fc[4]) && (dx < 11'd16) && (dy < 11'd16);
    rx = h ? dx[3:0] : 4'd0;
    ry = h ? dy[3:0] : 4'd0;
`ifdef SPRITE1_FLIPX_EN
    if (h && m_sh[30]) rx = 4'd15 - dx[3:0];
`endif
    if (fs) begin
      m_sh = sprite_data;
      m_fc = m_fc + 6'd1;
    end
    q1.push_back({h, rx, ry, m_fc});
    if (v) begin
      sp = ram_fn(rx, ry);
      oh = h & sp[24];
      q2.push_back({32'(cyc + 2), oh, oh ? sp[23:0] : bg});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 0, 0, 24'h0, 1'b0);
  endtask

  // Output monitor: stage-1 RAM address every cycle, composited pixel when valid.
  initial begin
    logic [14:0] e1;
    logic [56:0] e2;
    forever begin
      @(posedge HCLK);
      #1;
      if (HRESETn) begin
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          chk("in_sprite",   32'(in_sprite),   32'(e1[14]));
          chk("rel_x",       32'(rel_x),       32'(e1[13:10]));
          chk("rel_y",       32'(rel_y),       32'(e1[9:6]));
          chk("frame_count", 32'(frame_count), 32'(e1[5:0]));
        end
        if (out_valid) begin
          if (q2.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
          else begin
            e2 = q2.pop_front();
            chk("latency", 32'(cyc), e2[56:25]);
            chk("hit",     32'(hit), 32'(e2[24]));
            chk("out_rgb", 32'(out_rgb), 32'(e2[23:0]));
          end
        end else begin
          chk("idle_rgb", 32'(out_rgb), 32'd0);
        end
      end
    end
  end

  initial begin
    m_sh = '0; m_fc = '0;
    HRESETn = 1'b0; frame_start = 1'b0; pix_valid = 1'b1;
    pix_x = 10'd50; pix_y = 10'd10; bg_rgb = 24'h123456;
    sprite_data = 32'h8000_2832;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_out", {out_valid, hit, in_sprite, rel_x, rel_y, frame_count}, 32'd0);
    chk("rst_rgb", 32'(out_rgb), 32'd0);
    @(negedge HCLK);
    pix_valid = 1'b0;
    HRESETn   = 1'b1;

    // No frame_start yet: shadow disabled, background passes through.
    for (int i = 0; i < 4; i++) pix(1'b1, 48 + i, 10, 24'h100000 + 24'(i), 1'b0);
    idle(2);

    // Placement at X=50 Y=10.
    sprite_data = 32'h8000_2832;
    pix(1'b0, 0, 0, 24'h0, 1'b1);
    pix(1'b1, 50, 10, 24'h0000AA, 1'b0);
    pix(1'b1, 65, 25, 24'h0000AB, 1'b0);
    pix(1'b1, 66, 25, 24'h0000AC, 1'b0);
    pix(1'b1, 49, 10, 24'h0000AD, 1'b0);
    pix(1'b1, 57, 17, 24'h0000AE, 1'b0);
    pix(1'b1, 50, 26, 24'h0000AF, 1'b0);
    for (int i = 0; i < 20; i++) pix(1'b1, 44 + i, 9 + (i % 3) * 8, 24'h00B000 + 24'(i), 1'b0);
    idle(3);

    // Transparency.
    ram_en = 1'b1; ram_word = 32'h0100_FF00;
    pix(1'b1, 55, 12, 24'hABCDEF, 1'b0);
    pix(1'b1, 30, 12, 24'hABCDE0, 1'b0);
    idle(3);
    ram_word = 32'h0000_FF00;
    pix(1'b1, 55, 12, 24'hABCDEF, 1'b0);
    idle(3);
    ram_en = 1'b0;

    // Mid-frame move must not tear; coincident frame_start uses old shadow.
    sprite_data = 32'h8000_28C8;
    pix(1'b1, 50, 10, 24'h0C0000, 1'b0);
    pix(1'b1, 200, 10, 24'h0C0001, 1'b0);
    pix(1'b1, 50, 10, 24'h0C0002, 1'b1);
    pix(1'b1, 50, 10, 24'h0C0003, 1'b0);
    pix(1'b1, 200, 10, 24'h0C0004, 1'b0);
    pix(1'b1, 215, 25, 24'h0C0005, 1'b0);
    idle(2);

    // Unreachable position: X=1023, Y=511.
    sprite_data = 32'h87FF_FFFF;
    pix(1'b0, 0, 0, 24'h0, 1'b1);
    pix(1'b1, 639, 479, 24'h0D0000, 1'b0);
    pix(1'b1, 0, 0, 24'h0D0001, 1'b0);
    idle(2);

    // Blink across a full counter wrap.
    sprite_data = 32'hA000_2832;
    for (int f = 0; f < 68; f++) begin
      pix(1'b0, 0, 0, 24'h0, 1'b1);
      pix(1'b1, 52, 11, 24'h0E0000 + 24'(f), 1'b0);
    end
    idle(2);

    // Flip bit.
    sprite_data = 32'hC000_2832;
    pix(1'b0, 0, 0, 24'h0, 1'b1);
    pix(1'b1, 50, 10, 24'h0F0000, 1'b0);
    pix(1'b1, 53, 12, 24'h0F0001, 1'b0);
    idle(2);

    // Asynchronous reset in the middle of a line.
    pix(1'b1, 51, 10, 24'h111111, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_out", {out_valid, hit, in_sprite, rel_x, rel_y, frame_count}, 32'd0);
    chk("midrst_rgb", 32'(out_rgb), 32'd0);
    q1.delete(); q2.delete();
    m_sh = '0; m_fc = '0;
    @(negedge HCLK);
    pix_valid = 1'b0;
    HRESETn = 1'b1;
    idle(2);
    pix(1'b1, 50, 10, 24'h222222, 1'b0);
    idle(3);

    for (int i = 0; i < 20 && q2.size() > 0; i++) @(posedge HCLK);
    #2;
    chk("drain", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
